// File: rtl/vie_sram_arb_if.sv
// Request/response and SRAM bus bundle for the vie_sram_arb two-port SRAM arbiter.
// slave = arbiter side, master = requester side, sram = memory side.
interface vie_sram_arb_if #(
  parameter int unsigned AW = 32
);
  logic          inst_req_i;
  logic [3:0]    inst_wen_i;
  logic [AW-1:0] inst_addr_i;
  logic [31:0]   inst_wdata_i;
  logic          inst_gnt_o;
  logic          inst_rvalid_o;
  logic [31:0]   inst_rdata_o;

  logic          data_req_i;
  logic [3:0]    data_wen_i;
  logic [AW-1:0] data_addr_i;
  logic [31:0]   data_wdata_i;
  logic          data_gnt_o;
  logic          data_rvalid_o;
  logic [31:0]   data_rdata_o;

  logic          sram_en_o;
  logic [3:0]    sram_wen_o;
  logic [AW-1:0] sram_addr_o;
  logic [31:0]   sram_wdata_o;
  logic [31:0]   sram_rdata_i;

  modport slave (
    input  inst_req_i, inst_wen_i, inst_addr_i, inst_wdata_i,
    output inst_gnt_o, inst_rvalid_o, inst_rdata_o,
    input  data_req_i, data_wen_i, data_addr_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o,
    output sram_en_o, sram_wen_o, sram_addr_o, sram_wdata_o,
    input  sram_rdata_i
  );

  modport master (
    output inst_req_i, inst_wen_i, inst_addr_i, inst_wdata_i,
    input  inst_gnt_o, inst_rvalid_o, inst_rdata_o,
    output data_req_i, data_wen_i, data_addr_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o
  );

  modport sram (
    input  sram_en_o, sram_wen_o, sram_addr_o, sram_wdata_o,
    output sram_rdata_i
  );
endinterface

// File: rtl/vie_sram_arb.sv
// Two-port (inst/data) single-SRAM arbiter with one-cycle routed responses.
// Optional macro VIE_ARB_RR_EN: round-robin on contention instead of data priority with starvation guard.
module vie_sram_arb #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned AW         = 32
) (
  input  logic           clk,
  input  logic           rst,
  vie_sram_arb_if.slave  bus
);

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  logic          inst_gnt_s;
  logic          data_gnt_s;
  logic [3:0]    wen_s;
  logic [AW-1:0] addr_s;
  logic [31:0]   wdata_s;
  logic          inst_rvalid_s;
  logic          data_rvalid_s;
  logic [31:0]   rsp_data_s;

  owner_e        rsp_owner_r;
  logic          rsp_valid_r;
  logic          rsp_is_read_r;

`ifdef VIE_ARB_RR_EN
  owner_e        last_gnt_r;
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  logic [3:0]    starve_cnt_r;
`endif

  // Grant decision from current requests and arbitration state; nothing granted in reset
  always_comb begin
    inst_gnt_s = 1'b0;
    data_gnt_s = 1'b0;
    if (rst) begin
      inst_gnt_s = 1'b0;
      data_gnt_s = 1'b0;
    end else if (bus.inst_req_i && bus.data_req_i) begin
`ifdef VIE_ARB_RR_EN
      if (last_gnt_r == OWN_INST) begin
        data_gnt_s = 1'b1;
      end else begin
        inst_gnt_s = 1'b1;
      end
`else
      if (starve_cnt_r == STARVE_LIM) begin
        inst_gnt_s = 1'b1;
      end else begin
        data_gnt_s = 1'b1;
      end
`endif
    end else begin
      inst_gnt_s = bus.inst_req_i;
      data_gnt_s = bus.data_req_i;
    end
  end

  // SRAM command mux: winner's fields, all-zero when idle
  always_comb begin
    wen_s   = 4'h0;
    addr_s  = {AW{1'b0}};
    wdata_s = 32'h0;
    if (data_gnt_s) begin
      wen_s   = bus.data_wen_i;
      addr_s  = bus.data_addr_i;
      wdata_s = bus.data_wdata_i;
    end else if (inst_gnt_s) begin
      wen_s   = bus.inst_wen_i;
      addr_s  = bus.inst_addr_i;
      wdata_s = bus.inst_wdata_i;
    end else begin
      wen_s   = 4'h0;
      addr_s  = {AW{1'b0}};
      wdata_s = 32'h0;
    end
  end

  assign bus.inst_gnt_o   = inst_gnt_s;
  assign bus.data_gnt_o   = data_gnt_s;
  assign bus.sram_en_o    = inst_gnt_s | data_gnt_s;
  assign bus.sram_wen_o   = wen_s;
  assign bus.sram_addr_o  = addr_s;
  assign bus.sram_wdata_o = wdata_s;

  // Response routing; reset suppresses a response still in flight
  always_comb begin
    inst_rvalid_s = 1'b0;
    data_rvalid_s = 1'b0;
    rsp_data_s    = 32'h0;
    if (!rst && rsp_valid_r) begin
      if (rsp_owner_r == OWN_DATA) begin
        data_rvalid_s = 1'b1;
      end else begin
        inst_rvalid_s = 1'b1;
      end
    end else begin
      inst_rvalid_s = 1'b0;
      data_rvalid_s = 1'b0;
    end
    if (rsp_is_read_r) begin
      rsp_data_s = bus.sram_rdata_i;
    end else begin
      rsp_data_s = 32'h0;
    end
  end

  assign bus.inst_rvalid_o = inst_rvalid_s;
  assign bus.data_rvalid_o = data_rvalid_s;
  assign bus.inst_rdata_o  = inst_rvalid_s ? rsp_data_s : 32'h0;
  assign bus.data_rdata_o  = data_rvalid_s ? rsp_data_s : 32'h0;

  // Record owner and read/write kind of this cycle's grant for next-cycle routing
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_r   <= 1'b0;
      rsp_owner_r   <= OWN_INST;
      rsp_is_read_r <= 1'b0;
    end else begin
      rsp_valid_r   <= inst_gnt_s | data_gnt_s;
      rsp_owner_r   <= data_gnt_s ? OWN_DATA : OWN_INST;
      rsp_is_read_r <= (wen_s == 4'h0);
    end
  end

`ifdef VIE_ARB_RR_EN
  // Remember the most recent winner; reset leaves inst as last so data wins first
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_r <= OWN_INST;
    end else if (data_gnt_s) begin
      last_gnt_r <= OWN_DATA;
    end else if (inst_gnt_s) begin
      last_gnt_r <= OWN_INST;
    end else begin
      last_gnt_r <= last_gnt_r;
    end
  end
`else
  // Count consecutive refused inst cycles, saturating at the forced-grant threshold
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_r <= 4'h0;
    end else if (bus.inst_req_i && !inst_gnt_s) begin
      if (starve_cnt_r >= STARVE_LIM) begin
        starve_cnt_r <= STARVE_LIM;
      end else begin
        starve_cnt_r <= starve_cnt_r + 4'd1;
      end
    end else begin
      starve_cnt_r <= 4'h0;
    end
  end
`endif

endmodule

// File: tb/tb_vie_sram_arb.sv
// Scoreboard bench for vie_sram_arb: grants/SRAM command checked each cycle, responses popped one cycle later.
module tb_vie_sram_arb;
  localparam int unsigned SM = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vie_sram_arb_if #(.AW(32)) bus ();

  vie_sram_arb #(.STARVE_MAX(SM), .AW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic is_data;
    logic is_read;
  } rsp_t;

  rsp_t   sb[$];
  int     total = 0;
  int     bad = 0;
  int     starve_m = 0;
  logic   last_data_m = 1'b0;
  byte    gnt_char;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [3:0] iw, input logic [31:0] ia, input logic [31:0] iwd,
                       input logic dr, input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dwd);
    bus.inst_req_i   = ir;
    bus.inst_wen_i   = iw;
    bus.inst_addr_i  = ia;
    bus.inst_wdata_i = iwd;
    bus.data_req_i   = dr;
    bus.data_wen_i   = dw;
    bus.data_addr_i  = da;
    bus.data_wdata_i = dwd;
  endtask

  // One clock cycle: apply reset/rdata, predict, check at negedge, advance model
  task automatic run_cycle(input logic r, input logic [31:0] srd);
    logic ei, ed, xrvi, xrvd;
    logic [3:0] xw;
    logic [31:0] xa, xd, xri, xrd;
    rsp_t e;
    rst = r;
    bus.sram_rdata_i = srd;
    ei = 1'b0; ed = 1'b0;
    if (!r) begin
      if (bus.inst_req_i && bus.data_req_i) begin
`ifdef VIE_ARB_RR_EN
        if (last_data_m) ei = 1'b1; else ed = 1'b1;
`else
        if (starve_m == SM) ei = 1'b1; else ed = 1'b1;
`endif
      end else begin
        ei = bus.inst_req_i;
        ed = bus.data_req_i;
      end
    end
    xw = 4'h0; xa = 32'h0; xd = 32'h0;
    if (ed) begin
      xw = bus.data_wen_i; xa = bus.data_addr_i; xd = bus.data_wdata_i;
    end else if (ei) begin
      xw = bus.inst_wen_i; xa = bus.inst_addr_i; xd = bus.inst_wdata_i;
    end
    xrvi = 1'b0; xrvd = 1'b0; xri = 32'h0; xrd = 32'h0;
    if (r) begin
      sb.delete();
    end else if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.is_data) begin
        xrvd = 1'b1; xrd = e.is_read ? srd : 32'h0;
      end else begin
        xrvi = 1'b1; xri = e.is_read ? srd : 32'h0;
      end
    end
    @(negedge clk);
    check_eq("inst_gnt", {31'h0, bus.inst_gnt_o}, {31'h0, ei});
    check_eq("data_gnt", {31'h0, bus.data_gnt_o}, {31'h0, ed});
    check_eq("sram_en", {31'h0, bus.sram_en_o}, {31'h0, ei | ed});
    check_eq("sram_wen", {28'h0, bus.sram_wen_o}, {28'h0, xw});
    check_eq("sram_addr", bus.sram_addr_o, xa);
    check_eq("sram_wdata", bus.sram_wdata_o, xd);
    check_eq("inst_rvalid", {31'h0, bus.inst_rvalid_o}, {31'h0, xrvi});
    check_eq("data_rvalid", {31'h0, bus.data_rvalid_o}, {31'h0, xrvd});
    check_eq("inst_rdata", bus.inst_rdata_o, xri);
    check_eq("data_rdata", bus.data_rdata_o, xrd);
    gnt_char = bus.data_gnt_o ? 8'h44 : (bus.inst_gnt_o ? 8'h49 : 8'h2D);
    if (r) begin
      starve_m = 0;
      last_data_m = 1'b0;
    end else begin
      if (bus.inst_req_i && !ei) starve_m = (starve_m < SM) ? starve_m + 1 : SM;
      else starve_m = 0;
      if (ed) last_data_m = 1'b1;
      else if (ei) last_data_m = 1'b0;
    end
    if (ei || ed)
      sb.push_back('{is_data: ed, is_read: ed ? (bus.data_wen_i == 4'h0) : (bus.inst_wen_i == 4'h0)});
    @(posedge clk);
    #1;
  endtask

  string pat;

  initial begin
    drive(1'b1, 4'h0, 32'h1111_0000, 32'h0, 1'b1, 4'h3, 32'h2222_0000, 32'h5555_AAAA);
    // Requests held high during reset must not be granted
    run_cycle(1'b1, 32'h0);
    run_cycle(1'b1, 32'hFFFF_FFFF);

    // Inst-only read, data returned the next cycle
    drive(1'b1, 4'h0, 32'hBFC0_0000, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    run_cycle(1'b0, 32'h0);
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    run_cycle(1'b0, 32'h3C1D_0001);

    // Data full-word write; response carries zero data
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF);
    run_cycle(1'b0, 32'h1234_5678);
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    run_cycle(1'b0, 32'h8765_4321);

    // Continuous contention from reset
    run_cycle(1'b1, 32'h0);
`ifdef VIE_ARB_RR_EN
    pat = "DIDIDIDIDI";
`else
    pat = "DDDDIDDDDI";
`endif
    drive(1'b1, 4'h0, 32'h0000_0100, 32'h0, 1'b1, 4'h0, 32'h0000_0200, 32'h0);
    for (int i = 0; i < 10; i++) begin
      run_cycle(1'b0, 32'hA000_0000 + 32'(i));
      check_eq("grant_pattern", {24'h0, gnt_char}, {24'h0, pat[i]});
    end
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    run_cycle(1'b0, 32'hB000_0000);

    // Reset right after an inst read grant drops its response
    drive(1'b1, 4'h0, 32'h0000_0040, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    run_cycle(1'b0, 32'h0);
    run_cycle(1'b1, 32'hCAFE_F00D);
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    run_cycle(1'b0, 32'hCAFE_F00D);

    // Alternating single requesters, back-to-back
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) drive(1'b1, 4'h0, 32'h100 + 32'(i), 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
      else            drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h200 + 32'(i), 32'h0);
      run_cycle(1'b0, 32'hD000_0000 + 32'(i));
    end

    // Random traffic
    for (int i = 0; i < 120; i++) begin
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0, $urandom, $urandom,
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0, $urandom, $urandom);
      run_cycle(($urandom_range(0, 40) == 0), $urandom);
    end

    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    run_cycle(1'b0, 32'h0);
    check_eq("sb_drained", 32'(sb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
